// File: rtl/regf_wb_if.sv
// regf_wb_if: writeback request bus between the NUM_REQ writeback sources
// (master side) and regf_wb_arbiter (slave side). Requester i occupies
// req_rd_s[5i+4:5i] and req_rd_v[32i+31:32i].
interface regf_wb_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*5-1:0]  req_rd_s;
  logic [NUM_REQ*32-1:0] req_rd_v;
  logic [NUM_REQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_rd_s,
    output req_rd_v,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd_s,
    input  req_rd_v,
    output req_ready
  );
endinterface

// File: rtl/regf_wb_arbiter.sv
// regf_wb_arbiter: shares the register file write port among NUM_REQ
// writeback sources and tracks outstanding writes per register so decode
// can detect RAW hazards. Grant (p0) is combinational from req_valid; the
// write port register (p1) drives regf_we/rd_s/rd_v one cycle later.
// Build option: define WB_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with the lowest index winning.
module regf_wb_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic        clk,
  input  logic        rst,
  regf_wb_if.slave    wb,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_rd_s,
  output logic        alloc_ready,
  input  logic [4:0]  rs1_s,
  input  logic [4:0]  rs2_s,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        regf_we,
  output logic [4:0]  rd_s,
  output logic [31:0] rd_v
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int DATA_W = 32;

  // Pending-write counter update; holds at 3 and at 0 so it never wraps.
  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic inc,
                                          input logic dec);
    logic [1:0] n;
    n = c;
    if (inc && !dec)
      n = (c == 2'd3) ? c : c + 2'd1;
    else if (dec && !inc)
      n = (c == 2'd0) ? c : c - 2'd1;
    return n;
  endfunction

  logic [IDX_W-1:0]   gnt_idx_p0;
  logic               vld_p0;
  logic [NUM_REQ-1:0] gnt_p0;
  logic [4:0]         sel_rd_s_p0;
  logic [DATA_W-1:0]  sel_rd_v_p0;
  logic [31:1]        inc_p0;
  logic [31:1]        dec_p0;
  logic               alloc_fire;
  logic [1:0]         cnt_q [1:31];
  logic               we_p1;
  logic [4:0]         rd_s_p1;
  logic [DATA_W-1:0]  rd_v_p1;

  // ---- stage p0: arbitration ----
`ifdef WB_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int cand;
    cand       = 0;
    gnt_idx_p0 = '0;
    vld_p0     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_q) + 1 + k) % NUM_REQ;
      if (!rst && !vld_p0 && wb.req_valid[cand[IDX_W-1:0]]) begin
        vld_p0     = 1'b1;
        gnt_idx_p0 = cand[IDX_W-1:0];
      end
    end
  end

  // Pointer follows the granted index; it holds while nobody requests.
  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= IDX_W'(NUM_REQ - 1);
    else if (vld_p0)
      ptr_q <= gnt_idx_p0;
  end
`else
  // Fixed priority: scanning downwards leaves the lowest valid index.
  always_comb begin
    gnt_idx_p0 = '0;
    vld_p0     = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (!rst && wb.req_valid[k]) begin
        vld_p0     = 1'b1;
        gnt_idx_p0 = IDX_W'(k);
      end
    end
  end
`endif

  // One-hot grant and the granted requester's index/data.
  always_comb begin
    gnt_p0      = '0;
    sel_rd_s_p0 = '0;
    sel_rd_v_p0 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (vld_p0 && (gnt_idx_p0 == IDX_W'(k))) begin
        gnt_p0[k]   = 1'b1;
        sel_rd_s_p0 = wb.req_rd_s[5*k +: 5];
        sel_rd_v_p0 = wb.req_rd_v[DATA_W*k +: DATA_W];
      end
    end
  end

  assign wb.req_ready = gnt_p0;

  // Scoreboard lookups; x0 is never busy and a full counter blocks decode.
  always_comb begin
    alloc_ready = !rst && !((alloc_rd_s != 5'd0) && (cnt_q[alloc_rd_s] == 2'd3));
    rs1_busy    = !rst && (rs1_s != 5'd0) && (cnt_q[rs1_s] != 2'd0);
    rs2_busy    = !rst && (rs2_s != 5'd0) && (cnt_q[rs2_s] != 2'd0);
    alloc_fire  = alloc_valid && alloc_ready && (alloc_rd_s != 5'd0);
  end

  // Per-register increment (accepted allocation) and decrement (granted write).
  always_comb begin
    inc_p0 = '0;
    dec_p0 = '0;
    for (int r = 1; r < 32; r++) begin
      inc_p0[r] = alloc_fire && (alloc_rd_s == 5'(r));
      dec_p0[r] = vld_p0 && (sel_rd_s_p0 == 5'(r));
    end
  end

  // Pending-write counters; a same-register alloc and write cancel out.
  always_ff @(posedge clk) begin
    for (int r = 1; r < 32; r++) begin
      if (rst)
        cnt_q[r] <= 2'd0;
      else
        cnt_q[r] <= cnt_next(cnt_q[r], inc_p0[r], dec_p0[r]);
    end
  end

  // ---- stage p1: register file write port ----
  // Load on a grant (writes to x0 suppressed); otherwise drop the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_p1   <= 1'b0;
      rd_s_p1 <= '0;
      rd_v_p1 <= '0;
    end else if (vld_p0) begin
      we_p1   <= (sel_rd_s_p0 != 5'd0);
      rd_s_p1 <= sel_rd_s_p0;
      rd_v_p1 <= sel_rd_v_p0;
    end else begin
      we_p1   <= 1'b0;
    end
  end

  assign regf_we = we_p1;
  assign rd_s    = rd_s_p1;
  assign rd_v    = rd_v_p1;

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// tb_regf_wb_arbiter: directed test-plan sequences followed by randomized
// traffic, all checked each cycle against a behavioural model (per-register
// pending counts, last-granted index, expected write-port contents).
module tb_regf_wb_arbiter;
  localparam int NUM_REQ = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd_s;
  logic        alloc_ready;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        regf_we;
  logic [4:0]  rd_s;
  logic [31:0] rd_v;

  always #5 clk = ~clk;

  regf_wb_if #(.NUM_REQ(NUM_REQ)) wb ();

  regf_wb_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wb),
    .alloc_valid(alloc_valid),
    .alloc_rd_s (alloc_rd_s),
    .alloc_ready(alloc_ready),
    .rs1_s      (rs1_s),
    .rs2_s      (rs2_s),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .regf_we    (regf_we),
    .rd_s       (rd_s),
    .rd_v       (rd_v)
  );

  // Stimulus per requester
  logic [NUM_REQ-1:0] s_valid;
  logic [4:0]         s_rd [NUM_REQ];
  logic [31:0]        s_v  [NUM_REQ];

  // Reference model state
  int          m_cnt [32];
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_v;

  // Values observed at the last sampling point
  logic [NUM_REQ-1:0] obs_rdy;
  logic               obs_ar, obs_rs1b, obs_rs2b, obs_we;
  logic [4:0]         obs_rd;
  logic [31:0]        obs_v;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Which requester the arbitration rule picks, or -1 when none is valid.
  function automatic int pick(input logic [NUM_REQ-1:0] v);
    int r;
    r = -1;
`ifdef WB_ARB_RR_EN
    for (int k = 1; k <= NUM_REQ; k++)
      if (r < 0 && v[(m_ptr + k) % NUM_REQ]) r = (m_ptr + k) % NUM_REQ;
`else
    for (int i = 0; i < NUM_REQ; i++)
      if (r < 0 && v[i]) r = i;
`endif
    return r;
  endfunction

  function automatic logic busy_of(input logic [4:0] r);
    return !rst && (r != 5'd0) && (m_cnt[r] != 0);
  endfunction

  // One clock cycle: apply stimulus, check at negedge, advance model at posedge.
  task automatic step();
    int          g;
    logic        exp_ar;
    logic [4:0]  grd;
    for (int i = 0; i < NUM_REQ; i++) begin
      wb.req_rd_s[5*i +: 5]   = s_rd[i];
      wb.req_rd_v[32*i +: 32] = s_v[i];
    end
    wb.req_valid = s_valid;
    @(negedge clk);
    g      = rst ? -1 : pick(s_valid);
    exp_ar = !rst && !((alloc_rd_s != 5'd0) && (m_cnt[alloc_rd_s] == 3));
    obs_rdy = wb.req_ready; obs_ar = alloc_ready;
    obs_rs1b = rs1_busy; obs_rs2b = rs2_busy;
    obs_we = regf_we; obs_rd = rd_s; obs_v = rd_v;
    check_val("req_ready", 32'(obs_rdy), (g >= 0) ? (32'd1 << g) : 32'd0);
    check_val("alloc_ready", 32'(obs_ar), 32'(exp_ar));
    check_val("rs1_busy", 32'(obs_rs1b), 32'(busy_of(rs1_s)));
    check_val("rs2_busy", 32'(obs_rs2b), 32'(busy_of(rs2_s)));
    check_val("regf_we", 32'(obs_we), 32'(m_we));
    check_val("rd_s", 32'(obs_rd), 32'(m_rd));
    check_val("rd_v", obs_v, m_v);
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_ptr = NUM_REQ - 1;
      m_we = 1'b0; m_rd = '0; m_v = '0;
    end else begin
      grd = (g >= 0) ? s_rd[g] : 5'd0;
      if (g >= 0 && grd != 5'd0 && m_cnt[grd] == 0 &&
          !(alloc_valid && exp_ar && alloc_rd_s == grd))
        $display("note: protocol violation, write to x%0d with no pending allocation", grd);
      if (alloc_valid && exp_ar && alloc_rd_s != 5'd0) m_cnt[alloc_rd_s]++;
      if (g >= 0) begin
        if (grd != 5'd0 && m_cnt[grd] > 0) m_cnt[grd]--;
        m_we = (grd != 5'd0); m_rd = grd; m_v = s_v[g]; m_ptr = g;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    s_valid = '0; alloc_valid = 1'b0; alloc_rd_s = '0; rs1_s = '0; rs2_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin s_rd[i] = '0; s_v[i] = '0; end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  // Random destination among registers with outstanding allocations (or x0).
  function automatic logic [4:0] pend_reg();
    int q[$];
    for (int r = 1; r < 8; r++) if (m_cnt[r] > 0) q.push_back(r);
    if (q.size() == 0 || $urandom_range(0, 3) == 0) return 5'd0;
    return 5'(q[$urandom_range(0, q.size() - 1)]);
  endfunction

  initial begin
    int seq [6];
    m_ptr = NUM_REQ - 1; m_we = 1'b0; m_rd = '0; m_v = '0;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset();
    check_val("reset_we", 32'(regf_we), 32'd0);
    check_val("reset_rd_v", rd_v, 32'd0);

    // Single write
    s_valid = 3'b001; s_rd[0] = 5'd5; s_v[0] = 32'hDEADBEEF;
    step();
    check_val("single_ready", 32'(obs_rdy), 32'b001);
    s_valid = '0;
    step();
    check_val("single_we", 32'(obs_we), 32'd1);
    check_val("single_rd", 32'(obs_rd), 32'd5);
    check_val("single_v", obs_v, 32'hDEADBEEF);
    step();
    check_val("single_we_off", 32'(obs_we), 32'd0);

    // Contention from a fresh reset
    do_reset();
`ifdef WB_ARB_RR_EN
    seq = '{0, 1, 2, 0, 1, 2};
`else
    seq = '{0, 0, 0, 0, 0, 0};
`endif
    s_valid = 3'b111;
    for (int i = 0; i < NUM_REQ; i++) s_v[i] = 32'h100 + 32'(i);
    for (int k = 0; k < 6; k++) begin
      step();
      check_val("contention_gnt", 32'(obs_rdy), 32'd1 << seq[k]);
    end
    s_valid = '0;
    step();

    // Scoreboard on x7
    do_reset();
    alloc_valid = 1'b1; alloc_rd_s = 5'd7;
    step(); step();
    alloc_valid = 1'b0; rs1_s = 5'd7;
    step();
    check_val("sb_busy_two", 32'(obs_rs1b), 32'd1);
    s_valid = 3'b001; s_rd[0] = 5'd7; s_v[0] = 32'h7777_0001;
    step();
    s_valid = '0;
    step();
    check_val("sb_busy_one", 32'(obs_rs1b), 32'd1);
    s_valid = 3'b001; s_v[0] = 32'h7777_0002;
    step();
    s_valid = '0;
    step();
    check_val("sb_clear_we", 32'(obs_we), 32'd1);
    check_val("sb_clear_busy", 32'(obs_rs1b), 32'd0);
    alloc_valid = 1'b1;
    step();
    s_valid = 3'b001;
    step();
    alloc_valid = 1'b0; s_valid = '0;
    step();
    check_val("sb_simul_busy", 32'(obs_rs1b), 32'd1);
    s_valid = 3'b001;
    step();
    s_valid = '0;
    step();
    check_val("sb_simul_clear", 32'(obs_rs1b), 32'd0);

    // Saturation and x0
    alloc_valid = 1'b1; alloc_rd_s = 5'd3;
    step(); step(); step();
    step();
    check_val("sat_alloc_ready", 32'(obs_ar), 32'd0);
    alloc_rd_s = 5'd0; rs2_s = 5'd0;
    step();
    check_val("x0_alloc_ready", 32'(obs_ar), 32'd1);
    check_val("x0_rs2_busy", 32'(obs_rs2b), 32'd0);
    alloc_valid = 1'b0;
    s_valid = 3'b010; s_rd[1] = 5'd0; s_v[1] = 32'hABCD;
    step();
    s_valid = '0;
    step();
    check_val("x0_write_we", 32'(obs_we), 32'd0);

    // Reset mid-operation
    do_reset();
    alloc_valid = 1'b1; alloc_rd_s = 5'd4;
    step(); step(); step();
    alloc_valid = 1'b0;
    s_valid = 3'b001; s_rd[0] = 5'd4; s_v[0] = 32'h4444;
    step();
    rst = 1'b1; rs1_s = 5'd4;
    s_valid = 3'b110; s_rd[1] = 5'd0; s_rd[2] = 5'd0;
    step();
    check_val("rst_ready", 32'(obs_rdy), 32'd0);
    check_val("rst_rs1_busy", 32'(obs_rs1b), 32'd0);
    rst = 1'b0;
    step();
    check_val("rst_we_cancel", 32'(obs_we), 32'd0);
    check_val("rst_cnt_clear", 32'(obs_rs1b), 32'd0);
    check_val("rst_next_gnt", 32'(obs_rdy), 32'b010);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      alloc_valid = ($urandom_range(0, 1) == 1);
      alloc_rd_s  = 5'($urandom_range(0, 7));
      rs1_s       = 5'($urandom_range(0, 7));
      rs2_s       = 5'($urandom_range(0, 7));
      for (int i = 0; i < NUM_REQ; i++) begin
        s_valid[i] = ($urandom_range(0, 2) != 0);
        s_rd[i]    = pend_reg();
        s_v[i]     = $urandom();
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
